pc_fetch_unit: RTL and testbench



---
 rtl/rv_fetch_pkg.sv | 16 +
 rtl/pc_target_sel.sv | 23 ++
 rtl/pc_fetch_unit.sv | 84 ++++++++
 tb/tb_pc_fetch_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the program-counter / instruction-fetch front end.
package rv_fetch_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    STALL = 2'd2,
    TRAP  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/pc_target_sel.sv
// Redirect detection and next-PC target selection; JALR has priority and its bit 0 is cleared.
module pc_target_sel
  import rv_fetch_pkg::*;
(
  input  logic            branch_taken,
  input  logic            jump,
  input  logic            jalr,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] jalr_target,
  output logic            redirect_c,
  output logic [XLEN-1:0] target_c,
  output logic            misalign_c
);

  logic [XLEN-1:0] jalr_clr;

  assign jalr_clr   = jalr_target & ~XLEN'(1);
  assign redirect_c = branch_taken | jump | jalr;
  assign target_c   = jalr ? jalr_clr : branch_target;
  // Word fetches need both low bits clear once the JALR LSB has been dropped.
  assign misalign_c = redirect_c && (target_c[1:0] != 2'b00);

endmodule

// File: rtl/pc_fetch_unit.sv
// PC sequencer and instruction-fetch front end with req/ack memory handshake.
module pc_fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic        jalr,
  input  logic [31:0] branch_target,
  input  logic [31:0] jalr_target,
  input  logic        imem_ack,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc_value,
  output logic [31:0] pc_plus4,
  output logic        if_valid,
  output logic        flush,
  output logic        misaligned
);

  fetch_state_t    state;
  logic [XLEN-1:0] pc_q;
  logic            mis_q;

  logic            redirect_c;
  logic [XLEN-1:0] target_c;
  logic            misalign_c;
  logic            live_c;
  logic            fetching_c;

  pc_target_sel u_target_sel (
    .branch_taken (branch_taken),
    .jump         (jump),
    .jalr         (jalr),
    .branch_target(branch_target),
    .jalr_target  (jalr_target),
    .redirect_c   (redirect_c),
    .target_c     (target_c),
    .misalign_c   (misalign_c)
  );

  // TRAP ignores every input; elsewhere a stall suppresses the request immediately.
  assign live_c     = (state != TRAP);
  assign fetching_c = (state == FETCH) && !stall;

  assign imem_req   = fetching_c;
  assign if_valid   = fetching_c && imem_ack && !redirect_c;
  assign flush      = live_c && redirect_c && !misalign_c;
  assign pc_plus4   = pc_q + XLEN'(INSTR_BYTES);
  assign pc_value   = pc_q;
  assign imem_addr  = pc_q;
  assign misaligned = mis_q;

  // Priority each edge: reset > misaligned trap > redirect > stall > sequential advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= BOOT;
      pc_q  <= RESET_PC;
      mis_q <= 1'b0;
    end else if (live_c) begin
      if (misalign_c) begin
        state <= TRAP;
        mis_q <= 1'b1;
      end else if (redirect_c) begin
        pc_q  <= target_c;
        state <= stall ? STALL : FETCH;
      end else if (stall) begin
        state <= STALL;
      end else begin
        case (state)
          BOOT:  state <= FETCH;
          FETCH: if (imem_ack) pc_q <= pc_plus4;
          STALL: state <= FETCH;
          TRAP:  state <= TRAP;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed, table-driven bench for pc_fetch_unit; every row is one clock cycle of stimulus and expectation.
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic        jump;
  logic        jalr;
  logic [31:0] branch_target;
  logic [31:0] jalr_target;
  logic        imem_ack;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc_value;
  logic [31:0] pc_plus4;
  logic        if_valid;
  logic        flush;
  logic        misaligned;

  int n_cmp;
  int n_bad;

  pc_fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .branch_taken (branch_taken),
    .jump         (jump),
    .jalr         (jalr),
    .branch_target(branch_target),
    .jalr_target  (jalr_target),
    .imem_ack     (imem_ack),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .pc_value     (pc_value),
    .pc_plus4     (pc_plus4),
    .if_valid     (if_valid),
    .flush        (flush),
    .misaligned   (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        stall;
    logic        br;
    logic        jmp;
    logic        jalr;
    logic        ack;
    logic [31:0] bt;
    logic [31:0] jt;
    logic [31:0] pc;
    logic        req;
    logic        val;
    logic        fl;
    logic        mis;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic r, logic s, logic b, logic j, logic jr, logic a,
                              logic [31:0] bt, logic [31:0] jt, logic [31:0] pc,
                              logic rq, logic v, logic f, logic m);
    vec_t x;
    x.rst_n = r; x.stall = s; x.br = b; x.jmp = j; x.jalr = jr; x.ack = a;
    x.bt = bt; x.jt = jt; x.pc = pc; x.req = rq; x.val = v; x.fl = f; x.mis = m;
    return x;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    rst_n         = x.rst_n;
    stall         = x.stall;
    branch_taken  = x.br;
    jump          = x.jmp;
    jalr          = x.jalr;
    imem_ack      = x.ack;
    branch_target = x.bt;
    jalr_target   = x.jt;
  endtask

  task automatic check_row(input int row, input vec_t x);
    chk("pc_value",   row, pc_value,   x.pc);
    chk("imem_addr",  row, imem_addr,  x.pc);
    chk("pc_plus4",   row, pc_plus4,   32'(x.pc + 32'd4));
    chk("imem_req",   row, 32'(imem_req),   32'(x.req));
    chk("if_valid",   row, 32'(if_valid),   32'(x.val));
    chk("flush",      row, 32'(flush),      32'(x.fl));
    chk("misaligned", row, 32'(misaligned), 32'(x.mis));
  endtask

  initial begin
    vec_t hv;
    n_cmp = 0;
    n_bad = 0;

    //              rst s  br j  jr ack bt            jt            pc            rq v  f  m
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0000_0000, 0, 0, 0, 0)); // BOOT held in reset
    tv.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0000_0000, 0, 0, 0, 0)); // BOOT cycle
    tv.push_back(mk(1, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0000_0000, 1, 1, 0, 0));
    tv.push_back(mk(1, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0000_0004, 1, 1, 0, 0));
    tv.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0000_0008, 1, 0, 0, 0)); // ack delayed 3
    tv.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0000_0008, 1, 0, 0, 0));
    tv.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0000_0008, 1, 0, 0, 0));
    tv.push_back(mk(1, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0000_0008, 1, 1, 0, 0));
    tv.push_back(mk(1, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0000_000C, 1, 1, 0, 0));
    tv.push_back(mk(1, 0, 0, 1, 0, 0, 32'h20,       32'h0,        32'h0000_0010, 1, 0, 1, 0)); // JAL to 0x20
    tv.push_back(mk(1, 0, 1, 0, 0, 1, 32'h100,      32'h0,        32'h0000_0020, 1, 0, 1, 0)); // branch wins over ack
    tv.push_back(mk(1, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0000_0100, 1, 1, 0, 0));
    tv.push_back(mk(1, 0, 1, 1, 1, 1, 32'h300,      32'h201,      32'h0000_0104, 1, 0, 1, 0)); // jalr priority, bit0 cleared
    tv.push_back(mk(1, 0, 0, 1, 0, 0, 32'h40,       32'h0,        32'h0000_0200, 1, 0, 1, 0)); // back-to-back flush
    tv.push_back(mk(1, 1, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0000_0040, 0, 0, 0, 0)); // stall 1
    tv.push_back(mk(1, 1, 1, 0, 0, 1, 32'h80,       32'h0,        32'h0000_0040, 0, 0, 1, 0)); // stall 2 + branch
    tv.push_back(mk(1, 1, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0000_0080, 0, 0, 0, 0)); // stall 3
    tv.push_back(mk(1, 1, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0000_0080, 0, 0, 0, 0)); // stall 4
    tv.push_back(mk(1, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0000_0080, 0, 0, 0, 0)); // leaving STALL
    tv.push_back(mk(1, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0000_0080, 1, 1, 0, 0));
    tv.push_back(mk(1, 0, 0, 1, 0, 0, 32'hFFFF_FFFC, 32'h0,       32'h0000_0084, 1, 0, 1, 0));
    tv.push_back(mk(1, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'hFFFF_FFFC, 1, 1, 0, 0)); // wrap
    tv.push_back(mk(1, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0000_0000, 1, 1, 0, 0));
    tv.push_back(mk(1, 0, 0, 1, 0, 0, 32'h102,      32'h0,        32'h0000_0004, 1, 0, 0, 0)); // misaligned JAL
    tv.push_back(mk(1, 0, 1, 0, 0, 1, 32'h40,       32'h0,        32'h0000_0004, 0, 0, 0, 1)); // TRAP ignores all
    tv.push_back(mk(1, 1, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0000_0004, 0, 0, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0000_0004, 0, 0, 0, 1)); // reset exits TRAP
    tv.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0000_0000, 0, 0, 0, 0));
    tv.push_back(mk(1, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0000_0000, 1, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0000_0004, 1, 0, 0, 0)); // reset mid-fetch
    tv.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0000_0000, 0, 0, 0, 0));

    hv = mk(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0);
    drive(hv);
    @(posedge clk);

    foreach (tv[i]) begin
      @(negedge clk);
      drive(tv[i]);
      #1;
      check_row(i, tv[i]);
    end

    // JALR whose odd target becomes 0x202 after clearing bit 0: still traps.
    @(negedge clk);
    hv = mk(1, 0, 0, 0, 1, 1, 32'h0, 32'h203, 32'h0000_0000, 1, 0, 0, 0);
    drive(hv);
    #1;
    check_row(100, hv);
    @(negedge clk);
    hv = mk(1, 0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0000_0000, 0, 0, 0, 1);
    drive(hv);
    #1;
    check_row(101, hv);

    // Redirect during BOOT while stalled lands in STALL at the target.
    @(negedge clk);
    hv = mk(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0000_0000, 0, 0, 0, 1);
    drive(hv);
    #1;
    check_row(102, hv);
    @(negedge clk);
    hv = mk(1, 1, 1, 0, 0, 1, 32'h44, 32'h0, 32'h0000_0000, 0, 0, 1, 0);
    drive(hv);
    #1;
    check_row(103, hv);
    @(negedge clk);
    hv = mk(1, 1, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0000_0044, 0, 0, 0, 0);
    drive(hv);
    #1;
    check_row(104, hv);
    @(negedge clk);
    hv = mk(1, 0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0000_0044, 0, 0, 0, 0);
    drive(hv);
    #1;
    check_row(105, hv);
    @(negedge clk);
    hv = mk(1, 0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0000_0044, 1, 1, 0, 0);
    drive(hv);
    #1;
    check_row(106, hv);
    @(negedge clk);
    hv = mk(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0000_0048, 1, 0, 0, 0);
    drive(hv);
    #1;
    check_row(107, hv);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
